keypad_scan: RTL and testbench

//   Scans a 4x3 matrix keypad (0-9, *, #), debounces it, and produces one key code per

---
 rtl/keypad_scan_if.sv | 12 +
 rtl/keypad_scan.sv | 157 +++++++++++++++
 tb/tb_keypad_scan.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle between keypad_scan (master) and its consumer (slave).
// No buffering and no backpressure; key_valid is a one-cycle strobe.
interface keypad_scan_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input key_row, output key_col, key_code, key_valid, key_held);
  modport slave  (output key_row, input key_col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner/debouncer: one key_valid strobe per press, DEBOUNCE_CNT+1 clk after capture.
// No backpressure: the consumer must take key_code on the strobe cycle.
module keypad_scan #(
  parameter int SCAN_DIV     = 2,
  parameter int DEBOUNCE_CNT = 20
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    col_idx, col_nxt, next_col;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    row_pat, row_pat_nxt;
  logic [3:0]    code, code_nxt;
  logic          valid, valid_nxt;
  logic          held, held_nxt;
  logic          armed, armed_nxt;
  logic [1:0]    idle_cols, idle_nxt;
  logic [3:0]    low, row_low, mapped;
  logic [1:0]    row_sel;
  logic          none_low, one_low;

  assign low      = ~kp.key_row;
  assign none_low = (low == 4'd0);
  assign one_low  = !none_low && ((low & (low - 4'd1)) == 4'd0);
  assign next_col = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
  assign row_low  = ~row_pat;

  always_comb begin
    row_sel = 2'd0;
    case (row_low)
      4'b0010: row_sel = 2'd1;
      4'b0100: row_sel = 2'd2;
      4'b1000: row_sel = 2'd3;
      default: row_sel = 2'd0;
    endcase
    if (row_sel == 2'd3) begin
      case (col_idx)
        2'd0:    mapped = 4'hA;
        2'd1:    mapped = 4'h0;
        default: mapped = 4'hB;
      endcase
    end else begin
      mapped = 4'(row_sel) * 4'd3 + 4'(col_idx) + 4'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    div_nxt     = div_cnt;
    cnt_nxt     = cnt;
    row_pat_nxt = row_pat;
    code_nxt    = code;
    valid_nxt   = 1'b0;
    held_nxt    = held;
    armed_nxt   = armed;
    idle_nxt    = idle_cols;
    case (state)
      SCAN: begin
        if (div_cnt == DW'(SCAN_DIV - 1)) begin
          div_nxt = '0;
          col_nxt = next_col;
          // After reset, a full clean rotation is needed so a key held through reset is not reported.
          if (!armed) begin
            if (none_low) begin
              idle_nxt = idle_cols + 2'd1;
              if (idle_cols == 2'd2) armed_nxt = 1'b1;
            end else begin
              idle_nxt = 2'd0;
            end
          end else if (one_low) begin
            row_pat_nxt = kp.key_row;
            col_nxt     = col_idx;
            cnt_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (cnt == CW'(DEBOUNCE_CNT)) begin
          code_nxt  = mapped;
          valid_nxt = 1'b1;
          held_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = PRESSED;
        end else if (kp.key_row == row_pat) begin
          cnt_nxt = cnt + CW'(1);
        end else begin
          cnt_nxt   = '0;
          col_nxt   = next_col;
          state_nxt = SCAN;
        end
      end
      PRESSED: begin
        if (none_low) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt == CW'(DEBOUNCE_CNT)) begin
          held_nxt  = 1'b0;
          cnt_nxt   = '0;
          col_nxt   = next_col;
          state_nxt = SCAN;
        end else if (!none_low) begin
          cnt_nxt   = '0;
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      div_cnt   <= '0;
      cnt       <= '0;
      row_pat   <= 4'hF;
      code      <= 4'hF;
      valid     <= 1'b0;
      held      <= 1'b0;
      armed     <= 1'b0;
      idle_cols <= 2'd0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      div_cnt   <= div_nxt;
      cnt       <= cnt_nxt;
      row_pat   <= row_pat_nxt;
      code      <= code_nxt;
      valid     <= valid_nxt;
      held      <= held_nxt;
      armed     <= armed_nxt;
      idle_cols <= idle_nxt;
    end
  end

  assign kp.key_col   = ~(3'b001 << col_idx);
  assign kp.key_code  = code;
  assign kp.key_valid = valid;
  assign kp.key_held  = held;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad matrix model drives rows from the column drive,
// a scoreboard queue holds expected key codes, and strobes are checked as they appear.
module tb_keypad_scan;
  localparam int SCAN_DIV = 2;
  localparam int DB       = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kif();
  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (.clk(clk), .rst(rst), .kp(kif));

  // keys bit index = row*3 + col
  logic [11:0] keys = '0;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !kif.key_col[c]) rows[r] = 1'b0;
  end
  assign kif.key_row = rows;

  int tests = 0;
  int fails = 0;
  int sb[$];
  int n_pushed = 0;
  int n_valid  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_code(input int code);
    sb.push_back(code);
    n_pushed++;
  endtask

  logic [2:0] last_col   = 3'b111;
  logic       last_valid = 1'b0;
  int         cyc = 0, chg_cyc = 0;
  bit         chk_lat = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (kif.key_col !== last_col) chg_cyc = cyc;
    last_col = kif.key_col;
    if (!rst && kif.key_valid === 1'b1) begin
      n_valid++;
      check("strobe_count", n_valid, n_pushed);
      check("no_back_to_back", int'(last_valid), 0);
      check("held_at_strobe", int'(kif.key_held), 1);
      if (sb.size() > 0) check("key_code", int'(kif.key_code), sb.pop_front());
      if (chk_lat) check("latency", cyc - chg_cyc, SCAN_DIV + DB + 1);
    end
    last_valid = kif.key_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int start;
    int i;
    start = n_valid;
    i = 0;
    while (n_valid == start && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_strobe_seen"}, n_valid - start, 1);
  endtask

  task automatic wait_held_low(input string tag);
    int n;
    n = 0;
    while (kif.key_held === 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check({tag, "_held_fall_window"}, int'(n >= DB && n <= DB + 3), 1);
  endtask

  function automatic logic [2:0] rot(input logic [2:0] col);
    case (col)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  initial begin
    int bad, good, run, k;
    logic [2:0] prev;

    // T1 reset
    rst = 1'b1;
    tick(3);
    check("t1_col", int'(kif.key_col), 6);
    check("t1_code", int'(kif.key_code), 15);
    check("t1_valid", int'(kif.key_valid), 0);
    check("t1_held", int'(kif.key_held), 0);
    rst = 1'b0;
    tick(20);

    // T2 press '5'
    expect_code(5);
    keys[4] = 1'b1;
    wait_strobe("t2", 40);
    tick(15);
    check("t2_held", int'(kif.key_held), 1);
    check("t2_code_hold", int'(kif.key_code), 5);
    keys = '0;
    wait_held_low("t2");
    tick(10);
    check("t2_single", n_valid, n_pushed);

    // T3 press bounce on '3'
    chk_lat = 1'b0;
    k = 0;
    while (kif.key_col !== 3'b011 && k < 20) begin tick(1); k++; end
    check("t3_col2_reached", int'(kif.key_col), 3);
    keys[2] = 1'b1;
    tick(5);
    keys = '0;
    tick(2);
    check("t3_no_early_strobe", n_valid, n_pushed);
    expect_code(3);
    keys[2] = 1'b1;
    wait_strobe("t3", 40);
    tick(5);
    keys = '0;
    wait_held_low("t3");
    chk_lat = 1'b1;
    tick(10);

    // T4 release bounce on '0'
    expect_code(0);
    keys[10] = 1'b1;
    wait_strobe("t4", 40);
    tick(5);
    keys = '0;
    tick(10);
    check("t4_held_mid", int'(kif.key_held), 1);
    keys[10] = 1'b1;
    tick(3);
    check("t4_held_bounce", int'(kif.key_held), 1);
    keys = '0;
    wait_held_low("t4");
    check("t4_no_repeat", n_valid, n_pushed);
    tick(10);

    // T5 rows 1 and 2 low together on col0
    keys[3] = 1'b1;
    keys[6] = 1'b1;
    bad = 0; good = 0; run = 0;
    prev = kif.key_col;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      run++;
      if (kif.key_col !== prev) begin
        if (kif.key_col === rot(prev)) good++; else bad++;
        if (good > 1 && run != SCAN_DIV) bad++;
        run = 0;
        prev = kif.key_col;
      end
    end
    check("t5_bad_rotation", bad, 0);
    check("t5_rotating", int'(good >= 6), 1);
    check("t5_no_strobe", n_valid, n_pushed);
    keys = '0;
    tick(10);

    // T6 '*', '#', then reset mid-debounce of '7'
    expect_code(10);
    keys[9] = 1'b1;
    wait_strobe("t6_star", 40);
    tick(5);
    keys = '0;
    wait_held_low("t6_star");
    tick(5);
    expect_code(11);
    keys[11] = 1'b1;
    wait_strobe("t6_hash", 40);
    tick(5);
    keys = '0;
    wait_held_low("t6_hash");
    tick(5);
    keys[6] = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    check("t6_rst_code", int'(kif.key_code), 15);
    check("t6_rst_held", int'(kif.key_held), 0);
    check("t6_rst_col", int'(kif.key_col), 6);
    rst = 1'b0;
    tick(40);
    check("t6_no_strobe_held_thru_rst", n_valid, n_pushed);
    check("t6_code_still_none", int'(kif.key_code), 15);
    keys = '0;
    tick(20);
    expect_code(7);
    keys[6] = 1'b1;
    wait_strobe("t6_seven", 40);
    tick(5);
    keys = '0;
    wait_held_low("t6_seven");
    tick(5);

    check("sb_empty", sb.size(), 0);
    check("total_strobes", n_valid, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
